// File: rtl/ternary_serial_subtractor_pkg.sv
// Shared ternary datapath definitions: trit codes and the subtractor FSM states.
package ternary_pkg;

   localparam logic [1:0] TRIT_0   = 2'b00;
   localparam logic [1:0] TRIT_1   = 2'b01;
   localparam logic [1:0] TRIT_2   = 2'b10;
   localparam logic [1:0] TRIT_BAD = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic trit_bad(input logic [1:0] t);
      return (t == TRIT_BAD);
   endfunction

endpackage

// File: rtl/ternary_full_subtractor.sv
// Combinational ternary full subtractor: {bout,d} from x - y - bin, d in 0..2.
module ternary_full_subtractor
   import ternary_pkg::*;
(
   input  logic [1:0] x,
   input  logic [1:0] y,
   input  logic       bin,
   output logic [1:0] d,
   output logic       bout
);

   // Only the 18 legal input combinations are listed; any 11 input yields 0, no borrow.
   always_comb begin
      d    = TRIT_0;
      bout = 1'b0;
      case ({x, y, bin})
         {TRIT_0, TRIT_0, 1'b0}: begin d = TRIT_0; bout = 1'b0; end
         {TRIT_0, TRIT_0, 1'b1}: begin d = TRIT_2; bout = 1'b1; end
         {TRIT_0, TRIT_1, 1'b0}: begin d = TRIT_2; bout = 1'b1; end
         {TRIT_0, TRIT_1, 1'b1}: begin d = TRIT_1; bout = 1'b1; end
         {TRIT_0, TRIT_2, 1'b0}: begin d = TRIT_1; bout = 1'b1; end
         {TRIT_0, TRIT_2, 1'b1}: begin d = TRIT_0; bout = 1'b1; end
         {TRIT_1, TRIT_0, 1'b0}: begin d = TRIT_1; bout = 1'b0; end
         {TRIT_1, TRIT_0, 1'b1}: begin d = TRIT_0; bout = 1'b0; end
         {TRIT_1, TRIT_1, 1'b0}: begin d = TRIT_0; bout = 1'b0; end
         {TRIT_1, TRIT_1, 1'b1}: begin d = TRIT_2; bout = 1'b1; end
         {TRIT_1, TRIT_2, 1'b0}: begin d = TRIT_2; bout = 1'b1; end
         {TRIT_1, TRIT_2, 1'b1}: begin d = TRIT_1; bout = 1'b1; end
         {TRIT_2, TRIT_0, 1'b0}: begin d = TRIT_2; bout = 1'b0; end
         {TRIT_2, TRIT_0, 1'b1}: begin d = TRIT_1; bout = 1'b0; end
         {TRIT_2, TRIT_1, 1'b0}: begin d = TRIT_1; bout = 1'b0; end
         {TRIT_2, TRIT_1, 1'b1}: begin d = TRIT_0; bout = 1'b0; end
         {TRIT_2, TRIT_2, 1'b0}: begin d = TRIT_0; bout = 1'b0; end
         {TRIT_2, TRIT_2, 1'b1}: begin d = TRIT_2; bout = 1'b1; end
         default:                begin d = TRIT_0; bout = 1'b0; end
      endcase
   end

endmodule

// File: rtl/ternary_serial_subtractor.sv
// Digit-serial ternary subtractor: diff = (A - B) mod 3^N, one trit per clock, LSB first.
// state  | meaning
// S_IDLE | waiting for start; results from the last operation held
// S_RUN  | one trit of A - B per cycle, trit idx
// S_DONE | one-cycle done pulse, result valid
module ternary_serial_subtractor
   import ternary_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] a,
   input  logic [2*N-1:0] b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] diff,
   output logic           borrow,
   output logic           illegal
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   state_e           state_q, state_d;
   logic [2*N-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             chain_q, chain_d;
   logic             borrow_q, borrow_d;
   logic             illegal_q, illegal_d;

   logic [1:0]       x, y, d;
   logic             bout;
   logic             ops_bad;
   logic             last_step;

   always_comb begin
      ops_bad = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (trit_bad(a[2*i +: 2]) || trit_bad(b[2*i +: 2])) ops_bad = 1'b1;
      end
   end

   always_comb begin
      x = TRIT_0;
      y = TRIT_0;
      for (int i = 0; i < N; i++) begin
         if (idx_q == IDX_W'(i)) begin
            x = a_q[2*i +: 2];
            y = b_q[2*i +: 2];
         end
      end
   end

   assign last_step = (idx_q == IDX_W'(N - 1));

   ternary_full_subtractor u_fs (
      .x    (x),
      .y    (y),
      .bin  (chain_q),
      .d    (d),
      .bout (bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = ops_bad ? S_DONE : S_RUN;
         S_RUN:   if (last_step) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      diff_d    = diff_q;
      idx_d     = idx_q;
      chain_d   = chain_q;
      borrow_d  = borrow_q;
      illegal_d = illegal_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d       = a;
               b_d       = b;
               diff_d    = '0;
               borrow_d  = 1'b0;
               chain_d   = 1'b0;
               idx_d     = '0;
               illegal_d = ops_bad;
            end
         end
         S_RUN: begin
            for (int i = 0; i < N; i++) begin
               if (idx_q == IDX_W'(i)) diff_d[2*i +: 2] = d;
            end
            chain_d = bout;
            if (last_step) begin
               idx_d    = '0;
               borrow_d = bout;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         diff_q    <= '0;
         idx_q     <= '0;
         chain_q   <= 1'b0;
         borrow_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         diff_q    <= diff_d;
         idx_q     <= idx_d;
         chain_q   <= chain_d;
         borrow_q  <= borrow_d;
         illegal_q <= illegal_d;
      end
   end

   assign diff    = diff_q;
   assign borrow  = borrow_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_ternary_serial_subtractor.sv
// Scoreboard bench for the serial ternary subtractor: N=4 directed vectors, N=2 exhaustive sweep.
module tb_ternary_serial_subtractor;

   localparam int N4 = 4;
   localparam int N2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start4, busy4, done4, borrow4, illegal4;
   logic [7:0] a4, b4, diff4;
   logic       start2, busy2, done2, borrow2, illegal2;
   logic [3:0] a2, b2, diff2;

   ternary_serial_subtractor #(.N(N4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .illegal(illegal4)
   );

   ternary_serial_subtractor #(.N(N2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .illegal(illegal2)
   );

   typedef struct {
      logic [7:0] diff;
      logic       borrow;
      logic       illegal;
      int         cyc;
   } exp_t;

   exp_t sb4[$];
   exp_t sb2[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] enc(input int v, input int n);
      logic [7:0] r;
      int         t;
      r = '0;
      t = v;
      for (int i = 0; i < n; i++) begin
         r[2*i +: 2] = 2'(t % 3);
         t = t / 3;
      end
      return r;
   endfunction

   initial forever begin
      @(negedge clk);
      if (rst_n && done4) begin
         if (sb4.size() == 0) begin
            check("n4_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb4.pop_front();
            check("n4_diff",    {24'd0, diff4},    {24'd0, e.diff});
            check("n4_borrow",  {31'd0, borrow4},  {31'd0, e.borrow});
            check("n4_illegal", {31'd0, illegal4}, {31'd0, e.illegal});
            check("n4_done_cycle", cyc, e.cyc);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && done2) begin
         if (sb2.size() == 0) begin
            check("n2_unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb2.pop_front();
            check("n2_diff",    {28'd0, diff2},   {24'd0, e.diff});
            check("n2_borrow",  {31'd0, borrow2}, {31'd0, e.borrow});
            check("n2_done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic push4(input logic [7:0] d, input logic bo, input logic il, input int at);
      exp_t e;
      e.diff = d; e.borrow = bo; e.illegal = il; e.cyc = at;
      sb4.push_back(e);
   endtask

   // Caller is at a negedge with dut4 idle; returns the number of busy cycles seen.
   task automatic op4(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                      input logic eb, input logic ei, output int nbusy);
      int guard;
      a4 = av; b4 = bv; start4 = 1'b1;
      push4(ed, eb, ei, cyc + (ei ? 1 : N4 + 1));
      @(negedge clk);
      start4 = 1'b0;
      a4 = ~av; b4 = ~bv;
      nbusy = 0;
      guard = 0;
      while (busy4 && guard < 20) begin
         nbusy++;
         guard++;
         @(negedge clk);
      end
      if (guard >= 20) check("n4_op_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_idle4();
      int guard;
      guard = 0;
      while (busy4 && guard < 30) begin
         guard++;
         @(negedge clk);
      end
      if (guard >= 30) check("n4_idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int nb;
      int c;
      int guard;
      rst_n = 1'b0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      start2 = 1'b0; a2 = '0; b2 = '0;
      repeat (2) @(negedge clk);
      check("rst_outputs_n4", {20'd0, busy4, done4, diff4, borrow4, illegal4}, 32'd0);
      check("rst_outputs_n2", {24'd0, busy2, done2, diff2, borrow2, illegal2}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 2101 - 1012 = 1012
      op4(8'h91, 8'h46, 8'h46, 1'b0, 1'b0, nb);
      check("basic_busy_cycles", nb, N4 + 1);
      check("held_after_done", {23'd0, diff4, illegal4}, {23'd0, 8'h46, 1'b0});
      op4(8'h00, 8'h01, 8'hAA, 1'b1, 1'b0, nb);
      op4(8'h46, 8'h91, 8'h65, 1'b1, 1'b0, nb);

      // Illegal trit, then a legal op clears the flag.
      op4(8'h03, 8'h00, 8'h00, 1'b0, 1'b1, nb);
      check("illegal_busy_cycles", nb, 1);
      op4(8'h91, 8'h46, 8'h46, 1'b0, 1'b0, nb);

      // Start held high: equal operands, then max - 0 loaded while the first runs.
      c = cyc;
      a4 = 8'h91; b4 = 8'h91; start4 = 1'b1;
      push4(8'h00, 1'b0, 1'b0, c + 5);
      push4(8'hAA, 1'b0, 1'b0, c + 11);
      repeat (2) @(negedge clk);
      a4 = 8'hAA; b4 = 8'h00;
      while (cyc < c + 7) @(negedge clk);
      start4 = 1'b0;
      wait_idle4();

      // Stray starts during RUN and DONE, operands scrambled after acceptance.
      c = cyc;
      a4 = 8'h46; b4 = 8'h91; start4 = 1'b1;
      push4(8'h65, 1'b1, 1'b0, c + 5);
      @(negedge clk);
      start4 = 1'b0; a4 = 8'h91; b4 = 8'h46;
      @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      while (cyc < c + 5) @(negedge clk);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_start_idle", {31'd0, busy4}, 32'd0);

      // Asynchronous reset during the second RUN cycle.
      c = cyc;
      a4 = 8'h91; b4 = 8'h46; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      check("partial_trit0", {24'd0, diff4}, 32'h02);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {20'd0, busy4, done4, diff4, borrow4, illegal4}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op4(8'h00, 8'h01, 8'hAA, 1'b1, 1'b0, nb);

      // N=2 exhaustive against (A-B) mod 9.
      for (int ai = 0; ai < 9; ai++) begin
         for (int bi = 0; bi < 9; bi++) begin
            exp_t e;
            e.diff    = enc((ai - bi + 9) % 9, N2);
            e.borrow  = (ai < bi);
            e.illegal = 1'b0;
            e.cyc     = cyc + N2 + 1;
            sb2.push_back(e);
            a2 = enc(ai, N2)[3:0];
            b2 = enc(bi, N2)[3:0];
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            repeat (3) @(negedge clk);
         end
      end

      guard = 0;
      while ((sb4.size() != 0 || sb2.size() != 0) && guard < 20) begin
         guard++;
         @(negedge clk);
      end
      check("scoreboard_drained", sb4.size() + sb2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
